// File: rtl/itrans_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : itrans_pkg
//  Description : Shared types and constants for the inverse transform coder:
//                FSM state encoding, H.264 rescale table V[QP%6][class],
//                coefficient position classifier and QP clamp limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package itrans_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEQUANT = 3'd1,
        S_ROW     = 3'd2,
        S_COL     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [5:0] c_qp_max = 6'd51;

    // Position classes of the 4x4 block; they select the rescale column
    localparam logic [1:0] c_cls_a = 2'd0;
    localparam logic [1:0] c_cls_b = 2'd1;
    localparam logic [1:0] c_cls_c = 2'd2;

    // Rescale factors, row = QP%6, column = class a/b/c
    localparam logic [4:0] c_v_table [6][3] = '{
        '{5'd10, 5'd16, 5'd13},
        '{5'd11, 5'd18, 5'd14},
        '{5'd13, 5'd20, 5'd16},
        '{5'd14, 5'd23, 5'd18},
        '{5'd16, 5'd25, 5'd20},
        '{5'd18, 5'd29, 5'd23}
    };

    // Raster index to class: a = even row & even col, b = odd row & odd col
    function automatic logic [1:0] pos_class(input logic [3:0] pos);
        logic [1:0] cls;
        case (pos)
            4'd0, 4'd2, 4'd8, 4'd10:  cls = c_cls_a;
            4'd5, 4'd7, 4'd13, 4'd15: cls = c_cls_b;
            default:                  cls = c_cls_c;
        endcase
        return cls;
    endfunction

    function automatic logic [4:0] rescale_v(input logic [2:0] qp_mod, input logic [1:0] cls);
        return c_v_table[qp_mod][cls];
    endfunction

endpackage
`default_nettype wire

// File: rtl/itransform_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : itransform_butterfly
//  Description : Combinational 4-point 1-D H.264 inverse core transform.
//                Shared by the row and column passes of the block engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module itransform_butterfly #(
    parameter int BIT_LENGTH = 31
) (
    input  logic signed [BIT_LENGTH:0] i_x [4],
    output logic signed [BIT_LENGTH:0] o_y [4]
);

    logic signed [BIT_LENGTH:0] w_e;
    logic signed [BIT_LENGTH:0] w_f;
    logic signed [BIT_LENGTH:0] w_g;
    logic signed [BIT_LENGTH:0] w_h;

    // Even/odd decomposition followed by the output butterfly
    always_comb begin
        w_e    = i_x[0] + i_x[2];
        w_f    = i_x[0] - i_x[2];
        w_g    = (i_x[1] >>> 1) - i_x[3];
        w_h    = i_x[1] + (i_x[3] >>> 1);
        o_y[0] = w_e + w_h;
        o_y[1] = w_f + w_g;
        o_y[2] = w_f - w_g;
        o_y[3] = w_e - w_h;
    end

endmodule
`default_nettype wire

// File: rtl/inverse_transformcoder.sv
`default_nettype none
// ============================================================================
//  Module      : inverse_transformcoder
//  Description : Dequantizes one 4x4 block of H.264 levels and applies the
//                integer inverse core transform (rows, then columns) with
//                final (x+32)>>>6 rounding. Single block buffer, valid/ready
//                on both sides, global clock enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module inverse_transformcoder
    import itrans_pkg::*;
#(
    parameter int BIT_LENGTH = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [5:0]            QP,
    input  logic [BIT_LENGTH:0]   coeffs [16],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIT_LENGTH:0]   reconres [16],
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic signed [BIT_LENGTH:0] c_round = {{(BIT_LENGTH-6){1'b0}}, 7'd32};

    state_t                     r_state;
    state_t                     w_next;
    logic [1:0]                 r_idx;
    logic [5:0]                 r_qp;
    logic signed [BIT_LENGTH:0] r_buf      [16];
    logic signed [BIT_LENGTH:0] r_reconres [16];
    logic signed [BIT_LENGTH:0] w_deq      [16];
    logic signed [BIT_LENGTH:0] w_bf_in    [4];
    logic signed [BIT_LENGTH:0] w_bf_out   [4];
    logic signed [BIT_LENGTH:0] w_round    [4];
    logic [3:0]                 w_qp_div;
    logic [2:0]                 w_qp_mod;

    // State register; frozen while enable is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (enable) begin
            r_state <= w_next;
        end
    end

    // Next-state logic: fixed-length dequant/row/column sequence, then wait for consumer
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (in_valid && in_ready) w_next = S_DEQUANT;
            S_DEQUANT: w_next = S_ROW;
            S_ROW:     if (r_idx == 2'd3) w_next = S_COL;
            S_COL:     if (r_idx == 2'd3) w_next = S_DONE;
            S_DONE:    if (out_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready  = (r_state == S_IDLE) && enable;
        out_valid = (r_state == S_DONE);
    end

    // Rescale all 16 levels in parallel from the latched, already clamped QP
    always_comb begin
        w_qp_div = 4'(r_qp / 6'd6);
        w_qp_mod = 3'(r_qp % 6'd6);
        for (int i = 0; i < 16; i++) begin
            w_deq[i] = (r_buf[i] * $signed({{(BIT_LENGTH-4){1'b0}},
                        rescale_v(w_qp_mod, pos_class(4'(i)))})) <<< w_qp_div;
        end
    end

    // Butterfly input select: row idx during ROW, column idx during COL
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (r_state == S_COL) begin
                w_bf_in[k] = r_buf[{2'(k), r_idx}];
            end else begin
                w_bf_in[k] = r_buf[{r_idx, 2'(k)}];
            end
        end
    end

    itransform_butterfly #(
        .BIT_LENGTH (BIT_LENGTH)
    ) u_butterfly (
        .i_x (w_bf_in),
        .o_y (w_bf_out)
    );

    // Final residual rounding applied to the column pass results
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_round[k] = (w_bf_out[k] + c_round) >>> 6;
        end
    end

    // Block buffer, pass counter and output residual registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 2'd0;
            r_qp  <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i]      <= '0;
                r_reconres[i] <= '0;
            end
        end else if (enable) begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= 2'd0;
                    if (in_valid) begin
                        r_qp <= (QP > c_qp_max) ? c_qp_max : QP;
                        for (int i = 0; i < 16; i++) begin
                            r_buf[i] <= $signed(coeffs[i]);
                        end
                    end
                end
                S_DEQUANT: begin
                    for (int i = 0; i < 16; i++) begin
                        r_buf[i] <= w_deq[i];
                    end
                end
                S_ROW: begin
                    for (int k = 0; k < 4; k++) begin
                        r_buf[{r_idx, 2'(k)}] <= w_bf_out[k];
                    end
                    r_idx <= r_idx + 2'd1;
                end
                S_COL: begin
                    for (int k = 0; k < 4; k++) begin
                        r_reconres[{2'(k), r_idx}] <= w_round[k];
                    end
                    r_idx <= r_idx + 2'd1;
                end
                default: begin
                    r_idx <= 2'd0;
                end
            endcase
        end
    end

    // Expose residual registers on the unsigned output port
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            reconres[i] = r_reconres[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inverse_transformcoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inverse_transformcoder
//  Description : Scoreboard bench for inverse_transformcoder. Directed blocks
//                with hand-derived results plus random blocks checked against
//                an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inverse_transformcoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [5:0]  QP;
    logic [31:0] coeffs [16];
    logic        in_valid;
    logic        in_ready;
    logic [31:0] reconres [16];
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int exp_q [$];
    bit bp_rand = 1'b0;
    bit ready_req = 1'b1;

    int vt [6][3] = '{'{10, 16, 13}, '{11, 18, 14}, '{13, 20, 16},
                      '{14, 23, 18}, '{16, 25, 20}, '{18, 29, 23}};

    inverse_transformcoder #(.BIT_LENGTH(31)) dut (
        .clk       (clk),
        .reset     (rst),
        .enable    (enable),
        .QP        (QP),
        .coeffs    (coeffs),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reconres  (reconres),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer readiness: either the value requested by the main sequence or random
    always @(negedge clk) begin
        out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : ready_req;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void idct4(input int x[4], output int y[4]);
        int e, f, g, h;
        e = x[0] + x[2];
        f = x[0] - x[2];
        g = (x[1] >>> 1) - x[3];
        h = x[1] + (x[3] >>> 1);
        y[0] = e + h;
        y[1] = f + g;
        y[2] = f - g;
        y[3] = e - h;
    endfunction

    // Reference: rescale by class/QP, 1-D inverse on each row, then each column, then round
    function automatic void model(input int c[16], input int qp_in, output int r[16]);
        int qp, w[16], t[4], y[4], row, col, cls;
        qp = (qp_in > 51) ? 51 : qp_in;
        for (int i = 0; i < 16; i++) begin
            row = i / 4;
            col = i % 4;
            if (row % 2 == 0 && col % 2 == 0)      cls = 0;
            else if (row % 2 == 1 && col % 2 == 1) cls = 1;
            else                                   cls = 2;
            w[i] = (c[i] * vt[qp % 6][cls]) <<< (qp / 6);
        end
        for (int rr = 0; rr < 4; rr++) begin
            for (int k = 0; k < 4; k++) t[k] = w[4*rr + k];
            idct4(t, y);
            for (int k = 0; k < 4; k++) w[4*rr + k] = y[k];
        end
        for (int cc = 0; cc < 4; cc++) begin
            for (int k = 0; k < 4; k++) t[k] = w[4*k + cc];
            idct4(t, y);
            for (int k = 0; k < 4; k++) r[4*k + cc] = (y[k] + 32) >>> 6;
        end
    endfunction

    // Present a block once in_ready is seen; expected result queued at issue time
    task automatic send(input int c[16], input int qp, input bit push, input int e[16]);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!in_ready) begin
            if (n > 300) begin
                check("send_timeout", 0, 1);
                return;
            end
            n++;
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 16; i++) coeffs[i] = c[i];
        QP = 6'(qp);
        in_valid = 1'b1;
        if (push) for (int i = 0; i < 16; i++) exp_q.push_back(e[i]);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < 100) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                lat = cyc - accept_cyc;
                return;
            end
            n++;
        end
        check("out_valid_timeout", 0, 1);
    endtask

    // Scoreboard monitor: compares every block the DUT hands over
    always begin
        int e;
        int bad;
        @(negedge clk);
        #1;
        if (!rst && enable && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() < 16) begin
                errors++;
                $display("FAIL unexpected_block: got out_valid=1 expected no block (queued words %0d)", exp_q.size());
            end else begin
                bad = -1;
                for (int i = 0; i < 16; i++) begin
                    e = exp_q.pop_front();
                    if (bad < 0 && int'(reconres[i]) != e) begin
                        bad = i;
                        $display("FAIL block_data[%0d]: got %0d expected %0d", i, int'(reconres[i]), e);
                    end
                end
                if (bad >= 0) errors++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c[16], e[16];
        int lat, n, nz;
        logic [31:0] snap [16];

        rst = 1'b1;
        enable = 1'b1;
        in_valid = 1'b0;
        QP = 6'd0;
        for (int i = 0; i < 16; i++) coeffs[i] = '0;

        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        nz = 0;
        for (int i = 0; i < 16; i++) if (reconres[i] != 0) nz++;
        check("reset_reconres_nonzero", nz, 0);
        @(negedge clk);
        rst = 1'b0;

        // DC +64, QP 0 -> 10 everywhere, latency 9, then idle next cycle
        for (int i = 0; i < 16; i++) begin c[i] = 0; e[i] = 10; end
        c[0] = 64;
        send(c, 0, 1, e);
        wait_out(lat);
        check("latency_dc", lat, 9);
        @(negedge clk);
        #1;
        check("post_hs_out_valid", int'(out_valid), 0);
        check("post_hs_in_ready", int'(in_ready), 1);

        // DC -64 -> -10
        for (int i = 0; i < 16; i++) begin c[i] = 0; e[i] = -10; end
        c[0] = -64;
        send(c, 0, 1, e);
        wait_out(lat);
        check("latency_dc_neg", lat, 9);

        // QP 5, level 8 -> 2
        for (int i = 0; i < 16; i++) begin c[i] = 0; e[i] = 2; end
        c[0] = 8;
        send(c, 5, 1, e);
        wait_out(lat);

        // QP 6, level 64 -> 20
        for (int i = 0; i < 16; i++) begin c[i] = 0; e[i] = 20; end
        c[0] = 64;
        send(c, 6, 1, e);
        wait_out(lat);

        // AC at (0,1), QP 0 -> every row [13, 7, -6, -13]
        for (int i = 0; i < 16; i++) begin
            c[i] = 0;
            case (i % 4)
                0: e[i] = 13;
                1: e[i] = 7;
                2: e[i] = -6;
                default: e[i] = -13;
            endcase
        end
        c[1] = 64;
        send(c, 0, 1, e);
        wait_out(lat);

        // Zero block with 5 cycles of backpressure in DONE
        ready_req = 1'b0;
        for (int i = 0; i < 16; i++) begin c[i] = 0; e[i] = 0; end
        send(c, 17, 1, e);
        wait_out(lat);
        for (int i = 0; i < 16; i++) snap[i] = reconres[i];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            nz = 0;
            for (int i = 0; i < 16; i++) if (reconres[i] != snap[i]) nz++;
            check("bp_reconres_changed", nz, 0);
        end
        ready_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);

        // Enable low while idle blocks acceptance
        @(negedge clk);
        enable = 1'b0;
        #1;
        check("disabled_in_ready", int'(in_ready), 0);
        @(negedge clk);
        enable = 1'b1;

        // Reset during ROW discards the block (nothing queued for it)
        for (int i = 0; i < 16; i++) begin c[i] = 0; e[i] = 0; end
        c[0] = 640;
        c[5] = -99;
        send(c, 20, 0, e);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_in_ready", int'(in_ready), 1);
        nz = 0;
        for (int i = 0; i < 16; i++) if (reconres[i] != 0) nz++;
        check("midreset_reconres_nonzero", nz, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin c[i] = 0; e[i] = 10; end
        c[0] = 64;
        send(c, 0, 1, e);
        wait_out(lat);
        check("latency_after_reset", lat, 9);

        // Enable dropped 3 cycles during COL stretches latency to 12
        send(c, 0, 1, e);
        repeat (6) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_out(lat);
        check("latency_enable_gap", lat, 12);

        // QP 63 clamps to 51: 64*14<<8 = 229376 -> 3584
        for (int i = 0; i < 16; i++) begin c[i] = 0; e[i] = 3584; end
        c[0] = 64;
        send(c, 63, 1, e);
        wait_out(lat);

        // Random blocks against the reference model with random backpressure
        bp_rand = 1'b1;
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < 16; i++) begin
                if (b % 3 == 0 && $urandom_range(0, 3) != 0) c[i] = 0;
                else c[i] = int'($urandom_range(0, 65536)) - 32768;
            end
            n = (b % 8 == 0) ? 63 : int'($urandom_range(0, 63));
            model(c, n, e);
            send(c, n, 1, e);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        bp_rand = 1'b0;
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
